regfile_arbiter: RTL and testbench

- Shares the single 16x32 register memory (2 registered read ports, 1 negedge write port, active-low enables) between two requesters: req0 = filter engine, req1 = host/loader.
- Round-robin grants one combined read/write command per cycle and drives the register memory's address, data and enable pins from a registered command stage.
- Returns read data to the granted requester with fixed latency.

---
 rtl/regfile_arb_pkg.sv | 26 ++
 rtl/regfile_arbiter_rr_arb2.sv | 36 +++
 rtl/regfile_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_regfile_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-memory arbiter.
package regfile_arb_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    // Value the register memory presents on a read port whose enable was high (idle).
    localparam logic [DATA_W-1:0] RF_IDLE_DATA = 32'h0000_FFFF;

    typedef enum logic {
        FAV_REQ0 = 1'b0,
        FAV_REQ1 = 1'b1
    } rr_ptr_t;

    typedef struct packed {
        logic              rd_a_en;
        logic              rd_b_en;
        logic              wr_en;
        logic [ADDR_W-1:0] dir_a;
        logic [ADDR_W-1:0] dir_b;
        logic [ADDR_W-1:0] wr_dir;
        logic [DATA_W-1:0] wr_data;
        logic              owner;
    } rf_cmd_t;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips only when both requesters compete.
module rr_arb2
    import regfile_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    rr_ptr_t ptr_q, ptr_d;

    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        ptr_d = ptr_q;
        if (!rst) begin
            if (req0 && req1) begin
                gnt0  = (ptr_q == FAV_REQ0);
                gnt1  = (ptr_q == FAV_REQ1);
                ptr_d = (ptr_q == FAV_REQ0) ? FAV_REQ1 : FAV_REQ0;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= FAV_REQ0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one 16x32 register memory between the filter engine (req0) and host (req1).
// Optional grant counters are enabled with REGFILE_ARB_STATS_EN.
module regfile_arbiter #(
    parameter int ADDR_W = regfile_arb_pkg::ADDR_W,
    parameter int DATA_W = regfile_arb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_rd_a_en,
    input  logic              req0_rd_b_en,
    input  logic [ADDR_W-1:0] req0_dir_a,
    input  logic [ADDR_W-1:0] req0_dir_b,
    input  logic              req0_wr_en,
    input  logic [ADDR_W-1:0] req0_wr_dir,
    input  logic [DATA_W-1:0] req0_wr_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_rd_a_en,
    input  logic              req1_rd_b_en,
    input  logic [ADDR_W-1:0] req1_dir_a,
    input  logic [ADDR_W-1:0] req1_dir_b,
    input  logic              req1_wr_en,
    input  logic [ADDR_W-1:0] req1_wr_dir,
    input  logic [DATA_W-1:0] req1_wr_data,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data_a,
    output logic [DATA_W-1:0] rsp0_data_b,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data_a,
    output logic [DATA_W-1:0] rsp1_data_b,
    output logic [ADDR_W-1:0] rf_dir_a,
    output logic [ADDR_W-1:0] rf_dir_b,
    output logic [ADDR_W-1:0] rf_dir_wr,
    output logic              rf_re_a_n,
    output logic              rf_re_b_n,
    output logic              rf_we_n,
    output logic [DATA_W-1:0] rf_di,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
`endif
);

    import regfile_arb_pkg::*;

    logic    gnt0, gnt1, accept;
    rf_cmd_t cmd;

    logic              rf_re_a_n_q, rf_re_a_n_d, rf_re_b_n_q, rf_re_b_n_d;
    logic              rf_we_n_q, rf_we_n_d;
    logic [ADDR_W-1:0] rf_dir_a_q, rf_dir_a_d, rf_dir_b_q, rf_dir_b_d;
    logic [ADDR_W-1:0] rf_dir_wr_q, rf_dir_wr_d;
    logic [DATA_W-1:0] rf_di_q, rf_di_d;
    logic              vld_p0_q, vld_p0_d, owner_p0_q, owner_p0_d;
    logic              vld_p1_q, vld_p1_d, owner_p1_q, owner_p1_d;
    logic [DATA_W-1:0] hold0_a_q, hold0_a_d, hold0_b_q, hold0_b_d;
    logic [DATA_W-1:0] hold1_a_q, hold1_a_d, hold1_b_q, hold1_b_d;

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0_valid),
        .req1 (req1_valid),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 | gnt1;

    always_comb begin
        if (gnt1) begin
            cmd = '{rd_a_en: req1_rd_a_en, rd_b_en: req1_rd_b_en, wr_en: req1_wr_en,
                    dir_a: req1_dir_a, dir_b: req1_dir_b, wr_dir: req1_wr_dir,
                    wr_data: req1_wr_data, owner: 1'b1};
        end else begin
            cmd = '{rd_a_en: req0_rd_a_en, rd_b_en: req0_rd_b_en, wr_en: req0_wr_en,
                    dir_a: req0_dir_a, dir_b: req0_dir_b, wr_dir: req0_wr_dir,
                    wr_data: req0_wr_data, owner: 1'b0};
        end
    end

    // Stage p0: accepted command lands on the memory pins; idle cycles release the enables.
    always_comb begin
        rf_re_a_n_d = 1'b1;
        rf_re_b_n_d = 1'b1;
        rf_we_n_d   = 1'b1;
        rf_dir_a_d  = rf_dir_a_q;
        rf_dir_b_d  = rf_dir_b_q;
        rf_dir_wr_d = rf_dir_wr_q;
        rf_di_d     = rf_di_q;
        vld_p0_d    = accept;
        owner_p0_d  = owner_p0_q;
        if (accept) begin
            rf_re_a_n_d = ~cmd.rd_a_en;
            rf_re_b_n_d = ~cmd.rd_b_en;
            rf_we_n_d   = ~cmd.wr_en;
            rf_dir_a_d  = cmd.dir_a;
            rf_dir_b_d  = cmd.dir_b;
            rf_dir_wr_d = cmd.wr_dir;
            rf_di_d     = cmd.wr_data;
            owner_p0_d  = cmd.owner;
        end
    end

    // Stage p1: memory has sampled the reads; tag waits for its data to appear.
    always_comb begin
        vld_p1_d   = vld_p0_q;
        owner_p1_d = owner_p0_q;
        hold0_a_d  = rsp0_valid ? rf_data_a : hold0_a_q;
        hold0_b_d  = rsp0_valid ? rf_data_b : hold0_b_q;
        hold1_a_d  = rsp1_valid ? rf_data_a : hold1_a_q;
        hold1_b_d  = rsp1_valid ? rf_data_b : hold1_b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_re_a_n_q <= 1'b1;
            rf_re_b_n_q <= 1'b1;
            rf_we_n_q   <= 1'b1;
            rf_dir_a_q  <= '0;
            rf_dir_b_q  <= '0;
            rf_dir_wr_q <= '0;
            rf_di_q     <= '0;
            vld_p0_q    <= 1'b0;
            owner_p0_q  <= 1'b0;
            vld_p1_q    <= 1'b0;
            owner_p1_q  <= 1'b0;
            hold0_a_q   <= '0;
            hold0_b_q   <= '0;
            hold1_a_q   <= '0;
            hold1_b_q   <= '0;
        end else begin
            rf_re_a_n_q <= rf_re_a_n_d;
            rf_re_b_n_q <= rf_re_b_n_d;
            rf_we_n_q   <= rf_we_n_d;
            rf_dir_a_q  <= rf_dir_a_d;
            rf_dir_b_q  <= rf_dir_b_d;
            rf_dir_wr_q <= rf_dir_wr_d;
            rf_di_q     <= rf_di_d;
            vld_p0_q    <= vld_p0_d;
            owner_p0_q  <= owner_p0_d;
            vld_p1_q    <= vld_p1_d;
            owner_p1_q  <= owner_p1_d;
            hold0_a_q   <= hold0_a_d;
            hold0_b_q   <= hold0_b_d;
            hold1_a_q   <= hold1_a_d;
            hold1_b_q   <= hold1_b_d;
        end
    end

    assign rf_re_a_n = rf_re_a_n_q;
    assign rf_re_b_n = rf_re_b_n_q;
    assign rf_we_n   = rf_we_n_q;
    assign rf_dir_a  = rf_dir_a_q;
    assign rf_dir_b  = rf_dir_b_q;
    assign rf_dir_wr = rf_dir_wr_q;
    assign rf_di     = rf_di_q;

    // Read data is steered straight from the memory in the response cycle, held otherwise.
    assign rsp0_valid  = vld_p1_q & ~owner_p1_q;
    assign rsp1_valid  = vld_p1_q &  owner_p1_q;
    assign rsp0_data_a = rsp0_valid ? rf_data_a : hold0_a_q;
    assign rsp0_data_b = rsp0_valid ? rf_data_b : hold0_b_q;
    assign rsp1_data_a = rsp1_valid ? rf_data_a : hold1_a_q;
    assign rsp1_data_b = rsp1_valid ? rf_data_b : hold1_b_q;

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] grant_cnt0_q, grant_cnt0_d, grant_cnt1_q, grant_cnt1_d;

    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (gnt0 && grant_cnt0_q != 16'hFFFF) grant_cnt0_d = grant_cnt0_q + 16'd1;
        if (gnt1 && grant_cnt1_q != 16'hFFFF) grant_cnt1_d = grant_cnt1_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: register-memory model, spec-level scoreboard, directed vectors.
module tb_regfile_arbiter;

    localparam logic [31:0] IDLE = 32'h0000_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic        req0_valid = 0, req0_rd_a_en = 0, req0_rd_b_en = 0, req0_wr_en = 0;
    logic [3:0]  req0_dir_a = 0, req0_dir_b = 0, req0_wr_dir = 0;
    logic [31:0] req0_wr_data = 0;
    logic        req1_valid = 0, req1_rd_a_en = 0, req1_rd_b_en = 0, req1_wr_en = 0;
    logic [3:0]  req1_dir_a = 0, req1_dir_b = 0, req1_wr_dir = 0;
    logic [31:0] req1_wr_data = 0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data_a, rsp0_data_b, rsp1_data_a, rsp1_data_b;
    logic [3:0]  rf_dir_a, rf_dir_b, rf_dir_wr;
    logic        rf_re_a_n, rf_re_b_n, rf_we_n;
    logic [31:0] rf_di, rf_data_a, rf_data_b;
`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    regfile_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rd_a_en(req0_rd_a_en), .req0_rd_b_en(req0_rd_b_en),
        .req0_dir_a(req0_dir_a), .req0_dir_b(req0_dir_b),
        .req0_wr_en(req0_wr_en), .req0_wr_dir(req0_wr_dir), .req0_wr_data(req0_wr_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rd_a_en(req1_rd_a_en), .req1_rd_b_en(req1_rd_b_en),
        .req1_dir_a(req1_dir_a), .req1_dir_b(req1_dir_b),
        .req1_wr_en(req1_wr_en), .req1_wr_dir(req1_wr_dir), .req1_wr_data(req1_wr_data),
        .rsp0_valid(rsp0_valid), .rsp0_data_a(rsp0_data_a), .rsp0_data_b(rsp0_data_b),
        .rsp1_valid(rsp1_valid), .rsp1_data_a(rsp1_data_a), .rsp1_data_b(rsp1_data_b),
        .rf_dir_a(rf_dir_a), .rf_dir_b(rf_dir_b), .rf_dir_wr(rf_dir_wr),
        .rf_re_a_n(rf_re_a_n), .rf_re_b_n(rf_re_b_n), .rf_we_n(rf_we_n),
        .rf_di(rf_di), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b)
`ifdef REGFILE_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register memory: reads registered at posedge, writes latched at posedge and done at negedge.
    logic [31:0] rf_mem [16];
    bit          rf_init = 0;
    logic        wr_pend = 0;
    logic [3:0]  wr_addr = 0;
    logic [31:0] wr_dat = 0;

    always @(posedge clk) begin
        rf_data_a <= (rf_re_a_n !== 1'b0) ? IDLE : rf_mem[rf_dir_a];
        rf_data_b <= (rf_re_b_n !== 1'b0) ? IDLE : rf_mem[rf_dir_b];
        wr_pend   <= (rf_we_n === 1'b0);
        wr_addr   <= rf_dir_wr;
        wr_dat    <= rf_di;
    end

    always @(negedge clk) begin
        if (!rf_init) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 32'h100 + i;
            rf_init <= 1;
        end else if (wr_pend) begin
            rf_mem[wr_addr] <= wr_dat;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard model: architectural memory, favour bit and a queue of due responses.
    typedef struct {
        bit          owner;
        logic [31:0] a;
        logic [31:0] b;
        int          due;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mm [16];
    bit          model_init = 0;
    bit          fav = 0;
    logic [31:0] l0a = 0, l0b = 0, l1a = 0, l1b = 0;
    logic        n_re_a = 1, n_re_b = 1, n_we = 1;
    logic [3:0]  n_dir_a = 0, n_dir_b = 0, n_dir_wr = 0;
    logic [31:0] n_di = 0;

    always @(negedge clk) begin : model
        bit ev0, ev1, v0, v1, g, ca, cb, cw;
        logic [3:0] cda, cdb, cdw;
        logic [31:0] cwd, da, db;
        if (!model_init) begin
            for (int i = 0; i < 16; i++) mm[i] = 32'h100 + i;
            model_init = 1;
        end
        ev0 = 0;
        ev1 = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].owner) begin ev1 = 1; l1a = q[0].a; l1b = q[0].b; end
            else            begin ev0 = 1; l0a = q[0].a; l0b = q[0].b; end
            void'(q.pop_front());
        end
        chk1("rsp0_valid", rsp0_valid, ev0);
        chk1("rsp1_valid", rsp1_valid, ev1);
        chk("rsp0_data_a", rsp0_data_a, l0a);
        chk("rsp0_data_b", rsp0_data_b, l0b);
        chk("rsp1_data_a", rsp1_data_a, l1a);
        chk("rsp1_data_b", rsp1_data_b, l1b);
        chk1("rf_re_a_n", rf_re_a_n, n_re_a);
        chk1("rf_re_b_n", rf_re_b_n, n_re_b);
        chk1("rf_we_n", rf_we_n, n_we);
        chk("rf_dir_a", 32'(rf_dir_a), 32'(n_dir_a));
        chk("rf_dir_b", 32'(rf_dir_b), 32'(n_dir_b));
        chk("rf_dir_wr", 32'(rf_dir_wr), 32'(n_dir_wr));
        chk("rf_di", rf_di, n_di);

        n_re_a = 1; n_re_b = 1; n_we = 1;
        if (rst) begin
            q.delete();
            fav = 0;
            l0a = 0; l0b = 0; l1a = 0; l1b = 0;
            n_dir_a = 0; n_dir_b = 0; n_dir_wr = 0; n_di = 0;
            chk1("req0_ready", req0_ready, 1'b0);
            chk1("req1_ready", req1_ready, 1'b0);
        end else begin
            v0 = req0_valid;
            v1 = req1_valid;
            if (v0 && v1) begin g = fav; fav = !fav; end
            else g = v1;
            chk1("req0_ready", req0_ready, (v0 || v1) && !g);
            chk1("req1_ready", req1_ready, (v0 || v1) && g);
            if (v0 || v1) begin
                if (g) begin
                    ca = req1_rd_a_en; cb = req1_rd_b_en; cw = req1_wr_en;
                    cda = req1_dir_a; cdb = req1_dir_b; cdw = req1_wr_dir; cwd = req1_wr_data;
                end else begin
                    ca = req0_rd_a_en; cb = req0_rd_b_en; cw = req0_wr_en;
                    cda = req0_dir_a; cdb = req0_dir_b; cdw = req0_wr_dir; cwd = req0_wr_data;
                end
                da = ca ? mm[cda] : IDLE;
                db = cb ? mm[cdb] : IDLE;
                q.push_back('{owner: g, a: da, b: db, due: cyc + 2});
                if (cw) mm[cdw] = cwd;
                n_re_a = !ca; n_re_b = !cb; n_we = !cw;
                n_dir_a = cda; n_dir_b = cdb; n_dir_wr = cdw; n_di = cwd;
            end
        end
    end

    task automatic set_req(input bit n, input logic v, input logic rda, input logic rdb,
                           input logic wr, input logic [3:0] da, input logic [3:0] db,
                           input logic [3:0] dw, input logic [31:0] wd);
        if (!n) begin
            req0_valid = v; req0_rd_a_en = rda; req0_rd_b_en = rdb; req0_wr_en = wr;
            req0_dir_a = da; req0_dir_b = db; req0_wr_dir = dw; req0_wr_data = wd;
        end else begin
            req1_valid = v; req1_rd_a_en = rda; req1_rd_b_en = rdb; req1_wr_en = wr;
            req1_dir_a = da; req1_dir_b = db; req1_wr_dir = dw; req1_wr_data = wd;
        end
    endtask

    task automatic issue(input bit n, input logic rda, input logic rdb, input logic wr,
                         input logic [3:0] da, input logic [3:0] db, input logic [3:0] dw,
                         input logic [31:0] wd);
        set_req(n, 1, rda, rdb, wr, da, db, dw, wd);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic wait_rsp();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] pat;
        pat = 4'b0101;
        set_req(0, 1, 1, 1, 0, 4'd1, 4'd2, 4'd0, 32'd0);
        set_req(1, 1, 1, 1, 0, 4'd3, 4'd4, 4'd0, 32'd0);
        @(posedge clk); #1;
        repeat (3) begin
            @(negedge clk);
            chk1("rst_ready0", req0_ready, 1'b0);
            chk1("rst_ready1", req1_ready, 1'b0);
            chk1("rst_re_a_n", rf_re_a_n, 1'b1);
            chk1("rst_we_n", rf_we_n, 1'b1);
            chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
            @(posedge clk); #1;
        end
        rst = 0;

        // Contention: grants alternate 0,1,0,1; responses follow two cycles later.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("cont_ready0", req0_ready, pat[i]);
            chk1("cont_ready1", req1_ready, !pat[i]);
            if (i >= 2) chk1("cont_rsp0_order", rsp0_valid, pat[i-2]);
            @(posedge clk); #1;
        end
        req0_valid = 0;
        req1_valid = 0;
        @(posedge clk); #1;

        // Write then read back from the filter side.
        issue(1, 0, 0, 1, 4'd0, 4'd0, 4'd3, 32'd1);
        issue(0, 0, 0, 1, 4'd0, 4'd0, 4'd5, 32'hDEADBEEF);
        issue(0, 1, 0, 0, 4'd5, 4'd0, 4'd0, 32'd0);
        wait_rsp();
        chk1("wr_rd_valid", rsp0_valid, 1'b1);
        chk("wr_rd_data_a", rsp0_data_a, 32'hDEADBEEF);

        // Same-command read-after-write returns the old value; next command sees the new.
        @(posedge clk); #1;
        issue(1, 1, 0, 1, 4'd3, 4'd0, 4'd3, 32'd7);
        issue(1, 1, 0, 0, 4'd3, 4'd0, 4'd0, 32'd0);
        @(negedge clk);
        chk("raw_old", rsp1_data_a, 32'd1);
        @(negedge clk);
        chk("raw_new", rsp1_data_a, 32'd7);

        // Disabled read port and a write-only acknowledge.
        @(posedge clk); #1;
        issue(0, 1, 0, 0, 4'd1, 4'd2, 4'd0, 32'd0);
        wait_rsp();
        chk("dis_b_idle", rsp0_data_b, IDLE);
        chk("dis_a_data", rsp0_data_a, 32'h101);
        @(posedge clk); #1;
        issue(1, 0, 0, 1, 4'd0, 4'd0, 4'd9, 32'hAA);
        wait_rsp();
        chk1("wonly_valid", rsp1_valid, 1'b1);
        chk("wonly_b_idle", rsp1_data_b, IDLE);
        @(negedge clk);
        chk("hold_data", rsp1_data_b, IDLE);

        // Reset the cycle after an accept: that command never responds.
        @(posedge clk); #1;
        issue(0, 1, 1, 0, 4'd2, 4'd4, 4'd0, 32'd0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            chk1("mid_rst_no_rsp", rsp0_valid, 1'b0);
        end
        chk("mid_rst_data_clr", rsp0_data_a, 32'd0);

        @(posedge clk); #1;
        issue(0, 1, 0, 0, 4'd5, 4'd0, 4'd0, 32'd0);
        wait_rsp();
        chk("post_rst_read", rsp0_data_a, 32'hDEADBEEF);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
